// File: rtl/dm_port_arbiter.sv
// Two-port arbiter and access sequencer for the byte-addressed data memory; partial stores become read-modify-write.
// Optional macro DM_ARB_RR_EN selects round-robin arbitration; undefined gives fixed priority to port 0.
module dm_port_arbiter #(
   parameter int AW = 10,
   parameter int DW = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            m0_req,
   input  logic            m0_we,
   input  logic [DW/8-1:0] m0_be,
   input  logic [AW-1:0]   m0_addr,
   input  logic [DW-1:0]   m0_wdata,
   output logic            m0_ack,
   output logic [DW-1:0]   m0_rdata,
   input  logic            m1_req,
   input  logic            m1_we,
   input  logic [DW/8-1:0] m1_be,
   input  logic [AW-1:0]   m1_addr,
   input  logic [DW-1:0]   m1_wdata,
   output logic            m1_ack,
   output logic [DW-1:0]   m1_rdata,
   output logic [AW-1:0]   mem_addr,
   output logic            mem_we,
   output logic [DW-1:0]   mem_din,
   input  logic [DW-1:0]   mem_dout,
   output logic            busy
);

   // state  | meaning
   // IDLE   | waiting for a request; arbitration and field latch happen here
   // ACCESS | memory addressed; read capture, full write, or RMW read-back
   // MERGE  | write of the merged word for a partial store
   // ACK    | one-cycle ack to the granted port
   typedef enum logic [1:0] {IDLE, ACCESS, MERGE, ACK} state_t;

   localparam int NB = DW / 8;
   localparam logic [AW-1:0] WORD_MASK = {{(AW-2){1'b1}}, 2'b00};

   state_t          state_q, state_d;
   logic            gnt_q;
   logic            we_q;
   logic [NB-1:0]   be_q;
   logic [AW-1:0]   addr_q;
   logic [DW-1:0]   wdata_q;
   logic [DW-1:0]   merge_q;
   logic [DW-1:0]   merged;
   logic            win;
   logic            any_req;
   logic            be_full;
   logic            be_none;

   assign any_req = m0_req | m1_req;
   assign be_full = &be_q;
   assign be_none = ~|be_q;

`ifdef DM_ARB_RR_EN
   logic last_q;

   always_comb begin
      win = 1'b1;
      if (m0_req && m1_req) win = ~last_q;
      else if (m0_req)      win = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                            last_q <= 1'b1;
      else if (state_q == IDLE && any_req)   last_q <= win;
   end
`else
   assign win = ~m0_req;
`endif

   always_comb begin
      for (int i = 0; i < NB; i++)
         merged[8*i +: 8] = be_q[i] ? wdata_q[8*i +: 8] : mem_dout[8*i +: 8];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      mem_we  = 1'b0;
      mem_din = '0;
      m0_ack  = 1'b0;
      m1_ack  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (any_req) state_d = ACCESS;
         end
         ACCESS: begin
            state_d = ACK;
            if (we_q && be_full) begin
               mem_we  = 1'b1;
               mem_din = wdata_q;
            end else if (we_q && !be_none) begin
               state_d = MERGE;
            end
         end
         MERGE: begin
            mem_we  = 1'b1;
            mem_din = merge_q;
            state_d = ACK;
         end
         ACK: begin
            m0_ack  = ~gnt_q;
            m1_ack  = gnt_q;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // The full byte address is latched; lane bits are masked on the way out.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         gnt_q    <= 1'b0;
         we_q     <= 1'b0;
         be_q     <= '0;
         addr_q   <= '0;
         wdata_q  <= '0;
         merge_q  <= '0;
         m0_rdata <= '0;
         m1_rdata <= '0;
      end else begin
         if (state_q == IDLE && any_req) begin
            gnt_q   <= win;
            we_q    <= win ? m1_we    : m0_we;
            be_q    <= win ? m1_be    : m0_be;
            addr_q  <= win ? m1_addr  : m0_addr;
            wdata_q <= win ? m1_wdata : m0_wdata;
         end
         if (state_q == ACCESS) begin
            if (!we_q) begin
               if (gnt_q) m1_rdata <= mem_dout;
               else       m0_rdata <= mem_dout;
            end else if (!be_full && !be_none) begin
               merge_q <= merged;
            end
         end
      end
   end

   assign mem_addr = addr_q & WORD_MASK;
   assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_dm_port_arbiter.sv
// Directed bench for dm_port_arbiter with a behavioural 1 KB word memory.
module tb_dm_port_arbiter;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        m0_req = 1'b0, m0_we = 1'b0, m1_req = 1'b0, m1_we = 1'b0;
   logic [3:0]  m0_be = '0, m1_be = '0;
   logic [9:0]  m0_addr = '0, m1_addr = '0;
   logic [31:0] m0_wdata = '0, m1_wdata = '0;
   logic        m0_ack, m1_ack, mem_we, busy;
   logic [31:0] m0_rdata, m1_rdata, mem_din, mem_dout;
   logic [9:0]  mem_addr;
   logic [31:0] mem [0:255];
   int          passed = 0;
   int          total = 0;

   always #5 clk = ~clk;

   assign mem_dout = mem[mem_addr[9:2]];
   always @(posedge clk) if (mem_we) mem[mem_addr[9:2]] <= mem_din;

   dm_port_arbiter dut (
      .clk(clk), .rst_n(rst_n),
      .m0_req(m0_req), .m0_we(m0_we), .m0_be(m0_be), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
      .m0_ack(m0_ack), .m0_rdata(m0_rdata),
      .m1_req(m1_req), .m1_we(m1_we), .m1_be(m1_be), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
      .m1_ack(m1_ack), .m1_rdata(m1_rdata),
      .mem_addr(mem_addr), .mem_we(mem_we), .mem_din(mem_din), .mem_dout(mem_dout), .busy(busy)
   );

   task automatic start(input int port, input logic we, input logic [3:0] be,
                        input logic [9:0] addr, input logic [31:0] wdata);
      if (port == 0) begin
         m0_req = 1'b1; m0_we = we; m0_be = be; m0_addr = addr; m0_wdata = wdata;
      end else begin
         m1_req = 1'b1; m1_we = we; m1_be = be; m1_addr = addr; m1_wdata = wdata;
      end
   endtask

   task automatic stop();
      m0_req = 1'b0; m1_req = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      total++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b exp 0", busy); else passed++;
      total++; if ({m0_ack, m1_ack} !== 2'b00) $display("FAIL rst_ack: got %b exp 00", {m0_ack, m1_ack}); else passed++;
      total++; if (mem_we !== 1'b0) $display("FAIL rst_mem_we: got %b exp 0", mem_we); else passed++;
      total++; if (mem_addr !== 10'h0) $display("FAIL rst_mem_addr: got %h exp 000", mem_addr); else passed++;
      total++; if (mem_din !== 32'h0) $display("FAIL rst_mem_din: got %h exp 0", mem_din); else passed++;
      total++; if ({m0_rdata, m1_rdata} !== 64'h0) $display("FAIL rst_rdata: got %h exp 0", {m0_rdata, m1_rdata}); else passed++;
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_read();
      mem[8'h04] = 32'hDEADBEEF;
      mem[8'h05] = 32'h0BADF00D;
      start(0, 1'b0, 4'h0, 10'h010, 32'h0);
      @(negedge clk);
      total++; if (busy !== 1'b1) $display("FAIL rd_busy: got %b exp 1", busy); else passed++;
      total++; if (mem_addr !== 10'h010) $display("FAIL rd_addr: got %h exp 010", mem_addr); else passed++;
      total++; if (m0_ack !== 1'b0) $display("FAIL rd_early_ack: got %b exp 0", m0_ack); else passed++;
      @(negedge clk);
      total++; if (m0_ack !== 1'b1) $display("FAIL rd_ack_t2: got %b exp 1", m0_ack); else passed++;
      total++; if (m0_rdata !== 32'hDEADBEEF) $display("FAIL rd_data: got %h exp deadbeef", m0_rdata); else passed++;
      stop();
      @(negedge clk);
      total++; if ({m0_ack, busy} !== 2'b00) $display("FAIL rd_after: got %b exp 00", {m0_ack, busy}); else passed++;
      total++; if (m0_rdata !== 32'hDEADBEEF) $display("FAIL rd_hold: got %h exp deadbeef", m0_rdata); else passed++;
      mem[8'h04] = 32'h13579BDF;
      start(0, 1'b0, 4'h0, 10'h013, 32'h0);
      @(negedge clk);
      total++; if (mem_addr !== 10'h010) $display("FAIL rd2_addr: got %h exp 010", mem_addr); else passed++;
      @(negedge clk);
      total++; if (m0_ack !== 1'b1) $display("FAIL rd2_ack: got %b exp 1", m0_ack); else passed++;
      total++; if (m0_rdata !== 32'h13579BDF) $display("FAIL rd2_data: got %h exp 13579bdf", m0_rdata); else passed++;
      stop();
      @(negedge clk);
   endtask

   task automatic test_partial_write();
      mem[8'h08] = 32'hAABBCCDD;
      start(1, 1'b1, 4'b0101, 10'h020, 32'h11223344);
      @(negedge clk);
      total++; if (mem_we !== 1'b0) $display("FAIL pw_we_t1: got %b exp 0", mem_we); else passed++;
      total++; if (mem_addr !== 10'h020) $display("FAIL pw_addr: got %h exp 020", mem_addr); else passed++;
      @(negedge clk);
      total++; if (mem_we !== 1'b1) $display("FAIL pw_we_t2: got %b exp 1", mem_we); else passed++;
      total++; if (mem_din !== 32'hAA22CC44) $display("FAIL pw_din: got %h exp aa22cc44", mem_din); else passed++;
      total++; if (m1_ack !== 1'b0) $display("FAIL pw_early_ack: got %b exp 0", m1_ack); else passed++;
      @(negedge clk);
      total++; if ({m1_ack, mem_we} !== 2'b10) $display("FAIL pw_ack_t3: got %b exp 10", {m1_ack, mem_we}); else passed++;
      total++; if (mem[8'h08] !== 32'hAA22CC44) $display("FAIL pw_mem: got %h exp aa22cc44", mem[8'h08]); else passed++;
      stop();
      @(negedge clk);
      start(1, 1'b0, 4'h0, 10'h022, 32'h0);
      repeat (2) @(negedge clk);
      total++; if ({m1_ack, m1_rdata} !== {1'b1, 32'hAA22CC44}) $display("FAIL pw_readback: got %b/%h exp 1/aa22cc44", m1_ack, m1_rdata); else passed++;
      stop();
      @(negedge clk);
   endtask

   task automatic test_full_write();
      mem[8'h14] = 32'h0;
      start(0, 1'b1, 4'b1111, 10'h050, 32'hCAFEF00D);
      @(negedge clk);
      total++; if ({mem_we, mem_din} !== {1'b1, 32'hCAFEF00D}) $display("FAIL fw_t1: got %b/%h exp 1/cafef00d", mem_we, mem_din); else passed++;
      @(negedge clk);
      total++; if ({m0_ack, mem_we} !== 2'b10) $display("FAIL fw_ack_t2: got %b exp 10", {m0_ack, mem_we}); else passed++;
      total++; if (mem[8'h14] !== 32'hCAFEF00D) $display("FAIL fw_mem: got %h exp cafef00d", mem[8'h14]); else passed++;
      stop();
      @(negedge clk);
   endtask

   task automatic test_empty_write();
      int we_seen = 0;
      mem[8'h18] = 32'h5A5A5A5A;
      start(1, 1'b1, 4'b0000, 10'h060, 32'hFFFFFFFF);
      @(negedge clk);
      if (mem_we) we_seen++;
      @(negedge clk);
      if (mem_we) we_seen++;
      total++; if (m1_ack !== 1'b1) $display("FAIL ew_ack_t2: got %b exp 1", m1_ack); else passed++;
      stop();
      @(negedge clk);
      if (mem_we) we_seen++;
      total++; if (we_seen != 0) $display("FAIL ew_no_we: got %0d writes exp 0", we_seen); else passed++;
      total++; if (mem[8'h18] !== 32'h5A5A5A5A) $display("FAIL ew_mem: got %h exp 5a5a5a5a", mem[8'h18]); else passed++;
   endtask

   task automatic test_reset_in_merge();
      int ack_seen = 0;
      mem[8'h0C] = 32'h12345678;
      start(0, 1'b1, 4'b0011, 10'h030, 32'hFFFFFFFF);
      repeat (2) @(negedge clk);
      total++; if (mem_we !== 1'b1) $display("FAIL rm_in_merge: got %b exp 1", mem_we); else passed++;
      rst_n = 1'b0;
      #1;
      total++; if ({mem_we, busy} !== 2'b00) $display("FAIL rm_async: got %b exp 00", {mem_we, busy}); else passed++;
      stop();
      repeat (2) begin
         @(negedge clk);
         if (m0_ack || m1_ack) ack_seen++;
      end
      rst_n = 1'b1;
      @(negedge clk);
      if (m0_ack || m1_ack) ack_seen++;
      total++; if (ack_seen != 0) $display("FAIL rm_no_ack: got %0d acks exp 0", ack_seen); else passed++;
      total++; if (busy !== 1'b0) $display("FAIL rm_idle: got %b exp 0", busy); else passed++;
      total++; if (mem[8'h0C] !== 32'h12345678) $display("FAIL rm_mem: got %h exp 12345678", mem[8'h0C]); else passed++;
   endtask

   task automatic test_contention();
      int order [4];
      int n = 0;
      int cyc = 0;
      logic [3:0] exp_order;
`ifdef DM_ARB_RR_EN
      exp_order = 4'b1010;
`else
      exp_order = 4'b0000;
`endif
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      mem[8'h10] = 32'h00000A0A;
      mem[8'h11] = 32'h00000B0B;
      start(0, 1'b0, 4'h0, 10'h040, 32'h0);
      start(1, 1'b0, 4'h0, 10'h044, 32'h0);
      while (n < 4 && cyc < 40) begin
         @(negedge clk);
         cyc++;
         if (m0_ack) begin order[n] = 0; n++; end
         if (m1_ack && n < 4) begin order[n] = 1; n++; end
      end
      stop();
      @(negedge clk);
      total++; if (n != 4) $display("FAIL ct_count: got %0d acks exp 4 within budget", n); else passed++;
      for (int i = 0; i < 4; i++) begin
         total++;
         if (i < n && order[i] == int'(exp_order[i])) passed++;
         else $display("FAIL ct_grant%0d: got %0d exp %0d", i, (i < n) ? order[i] : -1, exp_order[i]);
      end
      total++; if (m0_rdata !== 32'h00000A0A) $display("FAIL ct_m0_data: got %h exp 00000a0a", m0_rdata); else passed++;
`ifdef DM_ARB_RR_EN
      total++; if (m1_rdata !== 32'h00000B0B) $display("FAIL ct_m1_data: got %h exp 00000b0b", m1_rdata); else passed++;
`else
      total++; if (m1_rdata !== 32'h0) $display("FAIL ct_m1_untouched: got %h exp 0", m1_rdata); else passed++;
`endif
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 32'h0;
      test_reset();
      test_read();
      test_partial_write();
      test_full_write();
      test_empty_write();
      test_reset_in_merge();
      test_contention();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
